// File: rtl/seq_pkg.sv
// Shared constants for the "010"/"11" serial pattern transmitter and detector family.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  localparam logic [2:0] PAT_A = 3'b010;
  localparam logic [1:0] PAT_B = 2'b11;

endpackage

// File: rtl/seq_match_model.sv
// Registered expected-match flag for "11" and "010" over a gated serial bit stream.
// The flag rises one cycle after the bit that completes a pattern; overlaps count.
module seq_match_model
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic bit_valid,
  output logic exp_match
);

  logic [1:0] hist_q, hist_d;
  logic [1:0] hist_cnt_q, hist_cnt_d;
  logic       exp_match_q, exp_match_d;

  always_comb begin
    hist_d      = hist_q;
    hist_cnt_d  = hist_cnt_q;
    exp_match_d = 1'b0;
    if (bit_valid) begin
      // hist_q[1] is the older bit; history survives word boundaries and gaps
      exp_match_d = ((hist_cnt_q != 2'd0) && ({hist_q[0], in_bit} == PAT_B)) ||
                    ((hist_cnt_q == 2'd2) && ({hist_q, in_bit} == PAT_A));
      hist_d      = {hist_q[0], in_bit};
      if (hist_cnt_q != 2'd2) begin
        hist_cnt_d = hist_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= 2'b00;
      hist_cnt_q  <= 2'd0;
      exp_match_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      hist_cnt_q  <= hist_cnt_d;
      exp_match_q <= exp_match_d;
    end
  end

  assign exp_match = exp_match_q;

endmodule

// File: rtl/seq_tx_010_11.sv
// Serial pattern transmitter: accepts a word over valid/ready and shifts it out MSB-first,
// with an aligned expected-match flag for the "010"/"11" detectors.
module seq_tx_010_11
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_match,
  output logic [LEN_W-1:0] bit_cnt
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [3:0]       GAP_L   = 4'(GAP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;

  always_comb begin
    eff_len = in_len;
    if ((in_len == '0) || (in_len > WIDTH_L)) begin
      eff_len = WIDTH_L;
    end
    // Left-justify the word so the shift register MSB is always the bit on the wire
    aligned = in_data << (WIDTH_L - eff_len);
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d     = ST_SHIFT;
          sreg_d      = aligned;
          bit_cnt_d   = eff_len;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          in_ready_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LEN_W'(1)) begin
          // Clearing the register forces data_out low outside SHIFT
          sreg_d      = '0;
          bit_cnt_d   = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          if (GAP_L != 4'd0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_L - 4'd1;
          end else begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
          end
        end else begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  seq_match_model u_match (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (sreg_q[WIDTH-1]),
    .bit_valid (out_valid_q),
    .exp_match (exp_match)
  );

  assign data_out  = sreg_q[WIDTH-1];
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_seq_tx_010_11.sv
// Directed bench for seq_tx_010_11: one instance with GAP=0, one with GAP=2.
module tb_seq_tx_010_11;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_a, in_valid_b;
  logic [7:0] in_data;
  logic [3:0] in_len;

  logic       in_ready_a, data_out_a, out_valid_a, busy_a, done_a, exp_match_a;
  logic [3:0] bit_cnt_a;
  logic       in_ready_b, data_out_b, out_valid_b, busy_b, done_b, exp_match_b;
  logic [3:0] bit_cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_tx_010_11 #(.WIDTH(8), .LEN_W(4), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .in_len(in_len), .data_out(data_out_a), .out_valid(out_valid_a),
    .busy(busy_a), .done(done_a), .exp_match(exp_match_a), .bit_cnt(bit_cnt_a)
  );

  seq_tx_010_11 #(.WIDTH(8), .LEN_W(4), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .in_len(in_len), .data_out(data_out_b), .out_valid(out_valid_b),
    .busy(busy_b), .done(done_b), .exp_match(exp_match_b), .bit_cnt(bit_cnt_b)
  );

  // Vector layout: {in_ready, out_valid, data_out, busy, done, exp_match, bit_cnt[3:0]}
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("ok   %s rdy/ov/d/busy/done/em/cnt=%b", tag, got);
    end else begin
      $display("FAIL %s got rdy/ov/d/busy/done/em/cnt=%b expected %b", tag, got, want);
    end
  endtask

  task automatic exp_a(input string tag, input logic rdy, input logic ov, input logic d,
                       input logic bsy, input logic dn, input logic em, input logic [3:0] cnt);
    check(tag, {in_ready_a, out_valid_a, data_out_a, busy_a, done_a, exp_match_a, bit_cnt_a},
          {rdy, ov, d, bsy, dn, em, cnt});
  endtask

  task automatic exp_b(input string tag, input logic rdy, input logic ov, input logic d,
                       input logic bsy, input logic dn, input logic em, input logic [3:0] cnt);
    check(tag, {in_ready_b, out_valid_b, data_out_b, busy_b, done_b, exp_match_b, bit_cnt_b},
          {rdy, ov, d, bsy, dn, em, cnt});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One-bit word on instance A, expecting exp_match value em after its bit
  task automatic send1_a(input string tag, input logic b, input logic em);
    in_data    = {7'b0, b};
    in_len     = 4'd1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    exp_a({tag, " bit"}, 0, 1, b, 1, 0, 0, 4'd1);
    tick();
    exp_a({tag, " after"}, 1, 0, 0, 0, 1, em, 4'd0);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] em_a5;
    logic [3:0] em_ff;
    a5    = 8'hA5;
    em_a5 = 8'b0000_1001;
    em_ff = 4'b0011;

    rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; in_data = 8'h00; in_len = 4'd0;
    tick();
    tick();
    exp_a("reset_a", 0, 0, 0, 0, 0, 0, 4'd0);
    exp_b("reset_b", 0, 0, 0, 0, 0, 0, 4'd0);
    rst = 1'b0;
    tick();
    exp_a("post_reset_a", 1, 0, 0, 0, 0, 0, 4'd0);

    // Single word "010"
    in_data = 8'b0000_0010; in_len = 4'd3; in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    exp_a("w010 T+1", 0, 1, 0, 1, 0, 0, 4'd3);
    tick(); exp_a("w010 T+2", 0, 1, 1, 1, 0, 0, 4'd2);
    tick(); exp_a("w010 T+3", 0, 1, 0, 1, 0, 0, 4'd1);
    tick(); exp_a("w010 T+4", 1, 0, 0, 0, 1, 1, 4'd0);
    tick(); exp_a("w010 T+5", 1, 0, 0, 0, 0, 0, 4'd0);

    // Overlap "11010"
    do_reset();
    in_data = 8'b0001_1010; in_len = 4'd5; in_valid_a = 1'b1;
    tick(); in_valid_a = 1'b0;
    exp_a("ovl T+1", 0, 1, 1, 1, 0, 0, 4'd5);
    tick(); exp_a("ovl T+2", 0, 1, 1, 1, 0, 0, 4'd4);
    tick(); exp_a("ovl T+3", 0, 1, 0, 1, 0, 1, 4'd3);
    tick(); exp_a("ovl T+4", 0, 1, 1, 1, 0, 0, 4'd2);
    tick(); exp_a("ovl T+5", 0, 1, 0, 1, 0, 0, 4'd1);
    tick(); exp_a("ovl T+6", 1, 0, 0, 0, 1, 1, 4'd0);
    tick(); exp_a("ovl T+7", 1, 0, 0, 0, 0, 0, 4'd0);

    // Cross-word history through a 2-cycle gap
    do_reset();
    exp_b("gap idle", 1, 0, 0, 0, 0, 0, 4'd0);
    in_data = 8'h01; in_len = 4'd1; in_valid_b = 1'b1;
    tick(); in_valid_b = 1'b0;
    exp_b("gap w1 bit", 0, 1, 1, 1, 0, 0, 4'd1);
    tick(); exp_b("gap cyc1", 0, 0, 0, 1, 1, 0, 4'd0);
    tick(); exp_b("gap cyc2", 0, 0, 0, 1, 0, 0, 4'd0);
    tick(); exp_b("gap idle2", 1, 0, 0, 0, 0, 0, 4'd0);
    in_valid_b = 1'b1;
    tick(); in_valid_b = 1'b0;
    exp_b("gap w2 bit", 0, 1, 1, 1, 0, 0, 4'd1);
    tick(); exp_b("gap w2 match", 0, 0, 0, 1, 1, 1, 4'd0);
    tick(); exp_b("gap w2 cyc2", 0, 0, 0, 1, 0, 0, 4'd0);
    tick(); exp_b("gap w2 idle", 1, 0, 0, 0, 0, 0, 4'd0);

    // in_len = 0 means full width; in_valid held high throughout
    do_reset();
    in_data = 8'hA5; in_len = 4'd0; in_valid_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_a($sformatf("len0 T+%0d", i), 0, 1, a5[8-i], 1, 0, em_a5[8-i], 4'(9 - i));
    end
    tick(); exp_a("len0 T+9", 1, 0, 0, 0, 1, 0, 4'd0);
    tick(); exp_a("len0 reaccept", 0, 1, 1, 1, 0, 0, 4'd8);
    in_valid_a = 1'b0;

    // Reset during the 4th valid cycle of 0xFF
    do_reset();
    in_data = 8'hFF; in_len = 4'd0; in_valid_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      in_valid_a = 1'b0;
      exp_a($sformatf("abort T+%0d", i), 0, 1, 1, 1, 0, em_ff[4-i], 4'(9 - i));
    end
    rst = 1'b1;
    tick(); exp_a("abort in rst", 0, 0, 0, 0, 0, 0, 4'd0);
    rst = 1'b0;
    tick(); exp_a("abort released", 1, 0, 0, 0, 0, 0, 4'd0);
    send1_a("post-abort 1", 1'b1, 1'b0);
    send1_a("post-abort 0a", 1'b0, 1'b0);
    send1_a("post-abort 0b", 1'b0, 1'b0);

    // Back-to-back words 01, 10 with in_valid held
    do_reset();
    in_data = 8'h01; in_len = 4'd2; in_valid_a = 1'b1;
    tick(); in_data = 8'h02;
    exp_a("b2b T+1", 0, 1, 0, 1, 0, 0, 4'd2);
    tick(); exp_a("b2b T+2", 0, 1, 1, 1, 0, 0, 4'd1);
    tick(); exp_a("b2b dead", 1, 0, 0, 0, 1, 0, 4'd0);
    tick(); in_valid_a = 1'b0;
    exp_a("b2b T+4", 0, 1, 1, 1, 0, 0, 4'd2);
    tick(); exp_a("b2b T+5", 0, 1, 0, 1, 0, 1, 4'd1);
    tick(); exp_a("b2b T+6", 1, 0, 0, 0, 1, 0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
